// File: rtl/inst_fetcher_pkg.sv
// Shared types for the instruction fetcher: FSM states and queue entry layout.
package inst_fetcher_pkg;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fq_entry_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher bus: icache request/response on one side, decoder/ROB on the other.
interface inst_fetcher_if;

  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_data;

  logic        valid;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        if_stall;
  logic        if_clear;
  logic [31:0] if_set_addr;
  logic        rob_clear;
  logic [31:0] rob_set_addr;

  modport master (
    output icache_req, icache_addr, valid, inst_addr, inst,
    input  icache_ready, icache_data, if_stall, if_clear, if_set_addr,
           rob_clear, rob_set_addr
  );

  modport slave (
    input  icache_req, icache_addr, valid, inst_addr, inst,
    output icache_ready, icache_data, if_stall, if_clear, if_set_addr,
           rob_clear, rob_set_addr
  );

endinterface

// File: rtl/inst_fetcher_fetch_queue.sv
// Circular FIFO of {addr, inst}; flush has priority over push/pop.
module inst_fetcher_fetch_queue
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned DEPTH_BIT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  fq_entry_t            push_data_i,
  output fq_entry_t            head_o,
  output logic [DEPTH_BIT:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_BIT;

  fq_entry_t              mem_q [DEPTH];
  logic [DEPTH_BIT-1:0]   rd_ptr_q, wr_ptr_q;
  logic [DEPTH_BIT:0]     count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + DEPTH_BIT'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + DEPTH_BIT'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (DEPTH_BIT+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_BIT+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: PC, single-outstanding icache FSM, stale-response drop
// and redirect priority; returned words are buffered in the fetch queue.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = 32'h0,
  parameter int unsigned QUEUE_DEPTH_BIT = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  inst_fetcher_if.master fetch
);

  fetch_state_e             state_q, state_d;
  logic                     drop_q, drop_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              addr_q, addr_d;

  logic                     redirect;
  logic [31:0]              target;
  logic                     issue, push, pop, flush, valid;
  fq_entry_t                push_data, head;
  logic [QUEUE_DEPTH_BIT:0] count;

  assign redirect = fetch.rob_clear | fetch.if_clear;
  assign target   = fetch.rob_clear ? fetch.rob_set_addr : fetch.if_set_addr;
  assign valid    = (count != '0);

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (rdy_in && !rst_in) begin
      if (redirect) begin
        flush = 1'b1;
        pc_d  = target;
        // A word arriving with the redirect is simply ignored; otherwise the
        // still-outstanding response is marked stale.
        if (state_q == S_WAIT) begin
          if (fetch.icache_ready) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
      end else begin
        pop = valid && !fetch.if_stall;
        case (state_q)
          S_IDLE: begin
            // count never exceeds depth, so its MSB alone means "full"
            if (!count[QUEUE_DEPTH_BIT]) begin
              issue   = 1'b1;
              addr_d  = pc_q;
              pc_d    = pc_q + INST_BYTES;
              state_d = S_WAIT;
              drop_d  = 1'b0;
            end
          end
          S_WAIT: begin
            if (fetch.icache_ready) begin
              push    = !drop_q;
              drop_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      pc_q    <= RESET_ADDR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign push_data = '{addr: addr_q, inst: fetch.icache_data};

  inst_fetcher_fetch_queue #(
    .DEPTH_BIT (QUEUE_DEPTH_BIT)
  ) u_fetch_queue (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .flush_i     (flush),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .head_o      (head),
    .count_o     (count)
  );

  // Request address is live from the PC in the issue cycle, then held.
  assign fetch.icache_req  = issue;
  assign fetch.icache_addr = issue ? pc_q : addr_q;
  assign fetch.valid       = valid;
  assign fetch.inst_addr   = head.addr;
  assign fetch.inst        = head.inst;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a 2-cycle icache model returning ~addr.
module tb_inst_fetcher;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  inst_fetcher_if bus ();

  inst_fetcher #(
    .RESET_ADDR      (32'h100),
    .QUEUE_DEPTH_BIT (2)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .fetch  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // icache model: response LAT cycles after the request, held until rdy_in high
  initial begin : icache
    logic        pend, consumed, seen_req;
    int          wt;
    logic [31:0] a, seen_addr;
    pend = 1'b0; wt = 0; a = '0;
    bus.icache_ready = 1'b0;
    bus.icache_data  = '0;
    forever begin
      @(negedge clk);
      consumed  = bus.icache_ready && rdy;
      seen_req  = bus.icache_req;
      seen_addr = bus.icache_addr;
      @(posedge clk); #1;
      if (consumed) begin
        bus.icache_ready = 1'b0;
        bus.icache_data  = '0;
      end
      if (pend) begin
        wt--;
        if (wt == 0) begin
          bus.icache_ready = 1'b1;
          bus.icache_data  = ~a;
          pend = 1'b0;
        end
      end
      if (seen_req) begin
        pend = 1'b1;
        wt   = LAT - 1;
        a    = seen_addr;
      end
    end
  end

  // logs of requests and decoder pops; counters of protocol violations
  logic [31:0] req_log[$];
  logic [31:0] pop_addr[$];
  logic [31:0] pop_inst[$];
  int          bad_req = 0;
  int          unstable = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0, prev_inst = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.icache_req) req_log.push_back(bus.icache_addr);
      if (bus.icache_req && !rdy) bad_req <= bad_req + 1;
      if (bus.valid && rdy && !bus.if_stall && !bus.if_clear && !bus.rob_clear) begin
        pop_addr.push_back(bus.inst_addr);
        pop_inst.push_back(bus.inst);
      end
      if (prev_hold && bus.valid && (bus.inst_addr !== prev_addr || bus.inst !== prev_inst))
        unstable <= unstable + 1;
    end
    prev_hold <= !rst && rdy && bus.valid && bus.if_stall && !bus.if_clear && !bus.rob_clear;
    prev_addr <= bus.inst_addr;
    prev_inst <= bus.inst;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // returns just after the edge that starts cycle 0 with reset released
  task automatic do_reset(input logic stall);
    rst = 1'b1;
    rdy = 1'b1;
    bus.if_stall     = stall;
    bus.if_clear     = 1'b0;
    bus.rob_clear    = 1'b0;
    bus.if_set_addr  = '0;
    bus.rob_set_addr = '0;
    cyc(4);
    rst = 1'b0;
  endtask

  int rb, pb, ub, bb;

  initial begin
    bus.if_stall = 1'b0; bus.if_clear = 1'b0; bus.rob_clear = 1'b0;
    bus.if_set_addr = '0; bus.rob_set_addr = '0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_iaddr", bus.inst_addr, 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_req", 32'(bus.icache_req), 32'd0);
    chk("rst_caddr", bus.icache_addr, 32'h0);

    // basic streaming, latency 2
    do_reset(1'b0);
    rb = req_log.size(); pb = pop_addr.size();
    @(negedge clk);
    chk("p1_req0", 32'(bus.icache_req), 32'd1);
    chk("p1_addr0", bus.icache_addr, 32'h100);
    cyc(1); @(negedge clk);
    chk("p1_pulse", 32'(bus.icache_req), 32'd0);
    chk("p1_hold", bus.icache_addr, 32'h100);
    cyc(1); @(negedge clk);
    chk("p1_v2", 32'(bus.valid), 32'd0);
    cyc(1); @(negedge clk);
    chk("p1_v3", 32'(bus.valid), 32'd1);
    chk("p1_ia3", bus.inst_addr, 32'h100);
    chk("p1_in3", bus.inst, 32'hFFFF_FEFF);
    chk("p1_req3", bus.icache_addr, 32'h104);
    cyc(7);
    chk("p1_nreq", 32'(req_log.size() - rb), 32'd4);
    chk("p1_npop", 32'(pop_addr.size() - pb), 32'd3);
    chk("p1_r2", req_log[rb+2], 32'h108);
    chk("p1_pa1", pop_addr[pb+1], 32'h104);
    chk("p1_pi1", pop_inst[pb+1], 32'hFFFF_FEFB);

    // stall until the queue fills, then drain
    do_reset(1'b1);
    rb = req_log.size(); pb = pop_addr.size(); ub = unstable;
    cyc(15); @(negedge clk);
    chk("p2_full_noreq", 32'(bus.icache_req), 32'd0);
    chk("p2_head", bus.inst_addr, 32'h100);
    cyc(1);
    chk("p2_nreq", 32'(req_log.size() - rb), 32'd4);
    chk("p2_npop", 32'(pop_addr.size() - pb), 32'd0);
    chk("p2_stable", 32'(unstable - ub), 32'd0);
    bus.if_stall = 1'b0;
    cyc(8);
    chk("p2_d0", pop_addr[pb+0], 32'h100);
    chk("p2_d1", pop_addr[pb+1], 32'h104);
    chk("p2_d2", pop_addr[pb+2], 32'h108);
    chk("p2_d3", pop_addr[pb+3], 32'h10C);
    chk("p2_d3i", pop_inst[pb+3], 32'hFFFF_FEF3);
    chk("p2_d4", pop_addr[pb+4], 32'h110);

    // if_clear while waiting on 0x10C
    do_reset(1'b1);
    rb = req_log.size(); pb = pop_addr.size();
    cyc(10);
    bus.if_clear = 1'b1; bus.if_set_addr = 32'h200;
    cyc(1);
    bus.if_clear = 1'b0; bus.if_stall = 1'b0;
    @(negedge clk);
    chk("p3_flushed", 32'(bus.valid), 32'd0);
    chk("p3_noreq", 32'(bus.icache_req), 32'd0);
    cyc(1); @(negedge clk);
    chk("p3_req", 32'(bus.icache_req), 32'd1);
    chk("p3_addr", bus.icache_addr, 32'h200);
    cyc(2); @(negedge clk);
    chk("p3_v14", 32'(bus.valid), 32'd0);
    cyc(1); @(negedge clk);
    chk("p3_v15", 32'(bus.valid), 32'd1);
    chk("p3_ia", bus.inst_addr, 32'h200);
    chk("p3_in", bus.inst, 32'hFFFF_FDFF);
    cyc(1);
    chk("p3_r3", req_log[rb+3], 32'h10C);
    chk("p3_r4", req_log[rb+4], 32'h200);
    chk("p3_pop0", pop_addr[pb], 32'h200);

    // rob_clear beats if_clear
    do_reset(1'b0);
    cyc(1);
    bus.rob_clear = 1'b1; bus.rob_set_addr = 32'h300;
    bus.if_clear  = 1'b1; bus.if_set_addr  = 32'h200;
    cyc(1);
    bus.rob_clear = 1'b0; bus.if_clear = 1'b0;
    cyc(1); @(negedge clk);
    chk("p4_drop", 32'(bus.valid), 32'd0);
    chk("p4_req", 32'(bus.icache_req), 32'd1);
    chk("p4_addr", bus.icache_addr, 32'h300);
    cyc(3); @(negedge clk);
    chk("p4_v", 32'(bus.valid), 32'd1);
    chk("p4_ia", bus.inst_addr, 32'h300);

    // icache_ready in the same cycle as a redirect
    do_reset(1'b0);
    cyc(2);
    bus.if_clear = 1'b1; bus.if_set_addr = 32'h200;
    cyc(1);
    bus.if_clear = 1'b0;
    @(negedge clk);
    chk("p5_nopush", 32'(bus.valid), 32'd0);
    chk("p5_req", bus.icache_addr, 32'h200);
    cyc(1); @(negedge clk);
    chk("p5_v4", 32'(bus.valid), 32'd0);
    cyc(1); @(negedge clk);
    chk("p5_v5", 32'(bus.valid), 32'd0);
    cyc(1); @(negedge clk);
    chk("p5_v6", 32'(bus.valid), 32'd1);
    chk("p5_ia", bus.inst_addr, 32'h200);

    // rdy_in low for 5 cycles while waiting
    do_reset(1'b0);
    rb = req_log.size(); bb = bad_req;
    cyc(1);
    rdy = 1'b0;
    cyc(2); @(negedge clk);
    chk("p6_frz_v", 32'(bus.valid), 32'd0);
    chk("p6_frz_req", 32'(bus.icache_req), 32'd0);
    cyc(3);
    rdy = 1'b1;
    @(negedge clk);
    chk("p6_v6", 32'(bus.valid), 32'd0);
    cyc(1); @(negedge clk);
    chk("p6_v7", 32'(bus.valid), 32'd1);
    chk("p6_ia", bus.inst_addr, 32'h100);
    chk("p6_in", bus.inst, 32'hFFFF_FEFF);
    chk("p6_req", bus.icache_addr, 32'h104);
    cyc(4);
    chk("p6_badreq", 32'(bad_req - bb), 32'd0);
    chk("p6_r0", req_log[rb+0], 32'h100);
    chk("p6_r2", req_log[rb+2], 32'h108);

    // reset asserted mid-WAIT: stale response must not be pushed
    do_reset(1'b0);
    cyc(1);
    rst = 1'b1;
    @(negedge clk);
    chk("p7_rst_v", 32'(bus.valid), 32'd0);
    chk("p7_rst_ca", bus.icache_addr, 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1); @(negedge clk);
    chk("p7_stale", 32'(bus.valid), 32'd0);
    cyc(2); @(negedge clk);
    chk("p7_v", 32'(bus.valid), 32'd1);
    chk("p7_ia", bus.inst_addr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
